// File: rtl/ysyx_23060203_trap_pkg.sv
// ============================================================================
// ysyx_23060203_trap_pkg : shared types and constants for the trap sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package ysyx_23060203_trap_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_SAVE     = 3'd1;
  localparam state_t S_VECTOR   = 3'd2;
  localparam state_t S_RESTORE  = 3'd3;
  localparam state_t S_LOADEPC  = 3'd4;
  localparam state_t S_REDIRECT = 3'd5;

  typedef enum logic {
    KIND_TRAP = 1'b0,
    KIND_MRET = 1'b1
  } trap_kind_e;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] s);
    logic [31:0] r;
    r                                = s;
    r[MSTATUS_MPIE]                  = s[MSTATUS_MIE];
    r[MSTATUS_MIE]                   = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] s);
    logic [31:0] r;
    r                                = s;
    r[MSTATUS_MIE]                   = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE]                  = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_23060203_trap_target.sv
// ============================================================================
// ysyx_23060203_trap_target : mtvec + cause to trap target PC (combinational)
// Option macro: YSYX_23060203_TRAP_VECTORED_EN enables vectored mode.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_23060203_trap_target (
  input  logic [31:0] mtvec_i,
  input  logic [31:0] cause_i,
  output logic [31:0] target_o
);

  logic [31:0] w_base;
  logic        w_unused;

  assign w_base = {mtvec_i[31:2], 2'b00};

`ifdef YSYX_23060203_TRAP_VECTORED_EN
  // Only interrupts (cause[31]) are vectored; exceptions always go to base.
  assign target_o = (mtvec_i[1:0] == 2'b01 && cause_i[31])
                    ? w_base + {cause_i[29:0], 2'b00}
                    : w_base;
  assign w_unused = cause_i[30];
`else
  assign target_o = w_base;
  assign w_unused = ^{cause_i, mtvec_i[1:0]};
`endif

endmodule

`default_nettype wire

// File: rtl/ysyx_23060203_trap_ctrl.sv
// ============================================================================
// ysyx_23060203_trap_ctrl : trap/MRET CSR sequencer with EXU CSR pass-through
// Option macro: YSYX_23060203_TRAP_VECTORED_EN (see trap_target).
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_23060203_trap_ctrl
  import ysyx_23060203_trap_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        trap_valid,
  output logic        trap_ready,
  input  logic        trap_kind,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic [11:0] exu_csr_raddr,
  output logic [31:0] exu_csr_rdata,
  input  logic        exu_csr_wen,
  input  logic [11:0] exu_csr_waddr,
  input  logic [31:0] exu_csr_wdata,
  output logic        exu_csr_ready,
  output logic [11:0] csr_raddr,
  input  logic [31:0] csr_rdata,
  output logic        csr_wen1,
  output logic [11:0] csr_waddr1,
  output logic [31:0] csr_wdata1,
  output logic        csr_wen2,
  output logic [11:0] csr_waddr2,
  output logic [31:0] csr_wdata2,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc
);

  state_t      state_q, state_d;
  logic [29:0] pc_q, pc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] target_q, target_d;
  logic [31:0] w_vec_target;
  logic        w_unused_pc;

  assign w_unused_pc = ^trap_pc[1:0];
  assign redirect_pc = target_q;

  ysyx_23060203_trap_target u_target (
    .mtvec_i  (csr_rdata),
    .cause_i  (cause_q),
    .target_o (w_vec_target)
  );

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    cause_d        = cause_q;
    mstatus_d      = mstatus_q;
    target_d       = target_q;
    trap_ready     = 1'b0;
    exu_csr_ready  = 1'b0;
    exu_csr_rdata  = '0;
    csr_raddr      = exu_csr_raddr;
    csr_wen1       = 1'b0;
    csr_waddr1     = '0;
    csr_wdata1     = '0;
    csr_wen2       = 1'b0;
    csr_waddr2     = '0;
    csr_wdata2     = '0;
    redirect_valid = 1'b0;
    // Write enables are qualified by rstn so a reset cycle never commits.
    case (state_q)
      S_IDLE: begin
        trap_ready    = rstn;
        exu_csr_ready = rstn;
        exu_csr_rdata = csr_rdata;
        csr_wen1      = exu_csr_wen & rstn;
        csr_waddr1    = exu_csr_waddr;
        csr_wdata1    = exu_csr_wdata;
        if (trap_valid && rstn) begin
          if (trap_kind == KIND_MRET) begin
            state_d = S_RESTORE;
          end else begin
            state_d = S_SAVE;
            pc_d    = trap_pc[31:2];
            cause_d = trap_cause;
          end
        end
      end
      S_SAVE: begin
        csr_wen1   = rstn;
        csr_waddr1 = CSR_MEPC;
        csr_wdata1 = {pc_q, 2'b00};
        csr_wen2   = rstn;
        csr_waddr2 = CSR_MCAUSE;
        csr_wdata2 = cause_q;
        csr_raddr  = CSR_MSTATUS;
        mstatus_d  = mstatus_on_trap(csr_rdata);
        state_d    = S_VECTOR;
      end
      S_VECTOR: begin
        csr_wen1   = rstn;
        csr_waddr1 = CSR_MSTATUS;
        csr_wdata1 = mstatus_q;
        csr_raddr  = CSR_MTVEC;
        target_d   = w_vec_target;
        state_d    = S_REDIRECT;
      end
      S_RESTORE: begin
        csr_raddr  = CSR_MSTATUS;
        csr_wen1   = rstn;
        csr_waddr1 = CSR_MSTATUS;
        csr_wdata1 = mstatus_on_mret(csr_rdata);
        state_d    = S_LOADEPC;
      end
      S_LOADEPC: begin
        csr_raddr = CSR_MEPC;
        target_d  = csr_rdata;
        state_d   = S_REDIRECT;
      end
      S_REDIRECT: begin
        redirect_valid = 1'b1;
        if (redirect_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      cause_q   <= '0;
      mstatus_q <= '0;
      target_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cause_q   <= cause_d;
      mstatus_q <= mstatus_d;
      target_q  <= target_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060203_trap_ctrl.sv
// ============================================================================
// tb_ysyx_23060203_trap_ctrl : bench for the trap sequencer with a CSR file
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_23060203_trap_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        trap_valid = 1'b0;
  logic        trap_ready;
  logic        trap_kind = 1'b0;
  logic [31:0] trap_pc = '0;
  logic [31:0] trap_cause = '0;
  logic [11:0] exu_csr_raddr = '0;
  logic [31:0] exu_csr_rdata;
  logic        exu_csr_wen = 1'b0;
  logic [11:0] exu_csr_waddr = '0;
  logic [31:0] exu_csr_wdata = '0;
  logic        exu_csr_ready;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_wen1, csr_wen2;
  logic [11:0] csr_waddr1, csr_waddr2;
  logic [31:0] csr_wdata1, csr_wdata2;
  logic        redirect_valid;
  logic        redirect_ready = 1'b0;
  logic [31:0] redirect_pc;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_mstatus = '0, m_mtvec = '0, m_mepc = '0, m_mcause = '0;
  logic [31:0] last_rpc = '0;

  logic [31:0] csr_mem [0:4095];
  assign csr_rdata = csr_mem[csr_raddr];

  always @(posedge clk) begin
    if (csr_wen1) csr_mem[csr_waddr1] <= csr_wdata1;
    if (csr_wen2) csr_mem[csr_waddr2] <= csr_wdata2;
  end

  always #5 clk = ~clk;

  ysyx_23060203_trap_ctrl dut (
    .clk            (clk),
    .rstn           (rstn),
    .trap_valid     (trap_valid),
    .trap_ready     (trap_ready),
    .trap_kind      (trap_kind),
    .trap_pc        (trap_pc),
    .trap_cause     (trap_cause),
    .exu_csr_raddr  (exu_csr_raddr),
    .exu_csr_rdata  (exu_csr_rdata),
    .exu_csr_wen    (exu_csr_wen),
    .exu_csr_waddr  (exu_csr_waddr),
    .exu_csr_wdata  (exu_csr_wdata),
    .exu_csr_ready  (exu_csr_ready),
    .csr_raddr      (csr_raddr),
    .csr_rdata      (csr_rdata),
    .csr_wen1       (csr_wen1),
    .csr_waddr1     (csr_waddr1),
    .csr_wdata1     (csr_wdata1),
    .csr_wen2       (csr_wen2),
    .csr_waddr2     (csr_waddr2),
    .csr_wdata2     (csr_wdata2),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_target(input logic [31:0] tvec, input logic [31:0] cause);
    logic [31:0] base;
    base = tvec & ~32'h3;
`ifdef YSYX_23060203_TRAP_VECTORED_EN
    if ((tvec & 32'h3) == 32'h1 && cause >= 32'h8000_0000)
      return base + (cause << 2);
`endif
    return base;
  endfunction

  task automatic check_csrs(input string tag);
    chk({tag, "_mstatus"}, csr_mem[12'h300], m_mstatus);
    chk({tag, "_mtvec"},   csr_mem[12'h305], m_mtvec);
    chk({tag, "_mepc"},    csr_mem[12'h341], m_mepc);
    chk({tag, "_mcause"},  csr_mem[12'h342], m_mcause);
  endtask

  task automatic exu_write(input logic [11:0] addr, input logic [31:0] data);
    @(negedge clk);
    exu_csr_wen   = 1'b1;
    exu_csr_waddr = addr;
    exu_csr_wdata = data;
    chk("exu_ready_idle", {31'd0, exu_csr_ready}, 32'd1);
    @(posedge clk);
    #1 exu_csr_wen = 1'b0;
    case (addr)
      12'h300: m_mstatus = data;
      12'h305: m_mtvec   = data;
      12'h341: m_mepc    = data;
      12'h342: m_mcause  = data;
      default: ;
    endcase
  endtask

  task automatic exu_read(input logic [11:0] addr, input logic [31:0] exp);
    @(negedge clk);
    exu_csr_raddr = addr;
    #1 chk("exu_rdata", exu_csr_rdata, exp);
  endtask

  // kind: 0 = TRAP, 1 = MRET. hold = cycles redirect_ready stays low.
  task automatic do_seq(input bit kind, input logic [31:0] pc, input logic [31:0] cause,
                        input int hold, input bit poke, input bit rst_mid);
    logic [31:0] exp_tgt, new_mstatus, rpc;
    int n;
    if (kind == 1'b0) begin
      exp_tgt     = ref_target(m_mtvec, cause);
      new_mstatus = (m_mstatus & ~32'h1888) | (((m_mstatus >> 3) & 32'h1) << 7) | 32'h1800;
    end else begin
      exp_tgt     = m_mepc;
      new_mstatus = (m_mstatus & ~32'h1888) | (((m_mstatus >> 7) & 32'h1) << 3) | 32'h1880;
    end
    @(negedge clk);
    trap_valid = 1'b1;
    trap_kind  = kind;
    trap_pc    = pc;
    trap_cause = cause;
    chk("trap_ready_idle", {31'd0, trap_ready}, 32'd1);
    @(posedge clk);
    #1 trap_valid = 1'b0;
    @(negedge clk);
    chk("t1_wen1", {31'd0, csr_wen1}, 32'd1);
    chk("t1_waddr1", {20'd0, csr_waddr1}, kind ? 32'h300 : 32'h341);
    chk("t1_wen2", {31'd0, csr_wen2}, kind ? 32'd0 : 32'd1);
    chk("exu_ready_busy", {31'd0, exu_csr_ready}, 32'd0);
    if (poke) begin
      exu_csr_wen   = 1'b1;
      exu_csr_waddr = 12'h305;
      exu_csr_wdata = 32'hDEAD_BEEC;
    end
    @(posedge clk);
    #1 exu_csr_wen = 1'b0;
    if (kind == 1'b0) begin
      m_mepc   = pc & ~32'h3;
      m_mcause = cause;
    end
    @(negedge clk);
    if (rst_mid) begin
      rstn = 1'b0;
      #1 chk("rst_wen1", {31'd0, csr_wen1}, 32'd0);
      chk("rst_wen2", {31'd0, csr_wen2}, 32'd0);
      chk("rst_trap_ready", {31'd0, trap_ready}, 32'd0);
      @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      chk("rst_rv", {31'd0, redirect_valid}, 32'd0);
      chk("rst_rpc", redirect_pc, 32'd0);
      chk("rst_idle", {31'd0, trap_ready}, 32'd1);
      check_csrs("rst");
      return;
    end
    chk("t2_wen1", {31'd0, csr_wen1}, kind ? 32'd0 : 32'd1);
    m_mstatus = new_mstatus;
    n = 2;
    while (!redirect_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("redirect_latency", n, 3);
    chk("redirect_pc", redirect_pc, exp_tgt);
    rpc = redirect_pc;
    for (int i = 0; i < hold; i++) begin
      trap_valid = 1'b1;
      trap_kind  = 1'b0;
      trap_cause = 32'h55;
      #1 chk("hold_valid", {31'd0, redirect_valid}, 32'd1);
      chk("hold_pc", redirect_pc, rpc);
      chk("hold_trap_ready", {31'd0, trap_ready}, 32'd0);
      chk("hold_rdata", exu_csr_rdata, 32'd0);
      @(negedge clk);
    end
    trap_valid     = 1'b0;
    redirect_ready = 1'b1;
    @(posedge clk);
    #1 redirect_ready = 1'b0;
    @(negedge clk);
    chk("after_rv", {31'd0, redirect_valid}, 32'd0);
    chk("after_trap_ready", {31'd0, trap_ready}, 32'd1);
    last_rpc = rpc;
    check_csrs(kind ? "mret" : "trap");
  endtask

  initial begin
    // Reset, with an EXU write held to prove it is blocked.
    exu_csr_wen   = 1'b1;
    exu_csr_waddr = 12'h300;
    exu_csr_wdata = 32'hFFFF_FFFF;
    repeat (2) begin
      @(negedge clk);
      chk("reset_trap_ready", {31'd0, trap_ready}, 32'd0);
      chk("reset_exu_ready", {31'd0, exu_csr_ready}, 32'd0);
      chk("reset_wen1", {31'd0, csr_wen1}, 32'd0);
    end
    exu_csr_wen = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("reset_rv", {31'd0, redirect_valid}, 32'd0);
    chk("reset_rpc", redirect_pc, 32'd0);
    chk("reset_idle_ready", {31'd0, trap_ready}, 32'd1);

    // Basic trap.
    exu_write(12'h300, 32'h0000_1800);
    exu_write(12'h305, 32'h8000_0100);
    do_seq(1'b0, 32'h8000_0010, 32'd11, 0, 1'b0, 1'b0);
    chk("tp1_mepc", csr_mem[12'h341], 32'h8000_0010);
    chk("tp1_mcause", csr_mem[12'h342], 32'd11);
    chk("tp1_mstatus", csr_mem[12'h300], 32'h0000_1800);
    chk("tp1_target", last_rpc, 32'h8000_0100);

    // MIE stacking and MRET unstacking.
    exu_write(12'h300, 32'h0000_1808);
    do_seq(1'b0, 32'h8000_0014, 32'd3, 0, 1'b0, 1'b0);
    chk("tp2_mstatus", csr_mem[12'h300], 32'h0000_1880);
    do_seq(1'b1, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    chk("tp2_mret_mstatus", csr_mem[12'h300], 32'h0000_1888);
    chk("tp2_mret_target", last_rpc, 32'h8000_0014);

    // Redirect back-pressure with ignored trap requests.
    do_seq(1'b0, 32'h8000_0020, 32'd2, 5, 1'b0, 1'b0);

    // EXU pass-through and blocked write while busy.
    exu_write(12'h305, 32'h8000_0200);
    exu_read(12'h305, 32'h8000_0200);
    do_seq(1'b0, 32'h8000_0030, 32'd4, 0, 1'b1, 1'b0);
    chk("poke_mtvec", csr_mem[12'h305], 32'h8000_0200);

    // Reset during VECTOR, then a clean trap.
    do_seq(1'b0, 32'h8000_0040, 32'd5, 0, 1'b0, 1'b1);
    do_seq(1'b0, 32'h8000_0044, 32'd6, 0, 1'b0, 1'b0);

    // Vectored mode.
    exu_write(12'h305, 32'h8000_0101);
    do_seq(1'b0, 32'h8000_0050, 32'h8000_0007, 0, 1'b0, 1'b0);
`ifdef YSYX_23060203_TRAP_VECTORED_EN
    chk("vec_target", last_rpc, 32'h8000_011C);
`else
    chk("vec_target", last_rpc, 32'h8000_0100);
`endif

    // Randomized sequences.
    for (int it = 0; it < 30; it++) begin
      logic [31:0] cause;
      if ($urandom_range(0, 2) == 0)
        exu_write(12'h300, $urandom & 32'h0000_1888);
      if ($urandom_range(0, 2) == 0)
        exu_write(12'h305, {$urandom_range(32'h8000, 32'h80FF), 14'd0, 2'($urandom_range(0, 3))});
      if ($urandom_range(0, 1) == 1)
        cause = 32'h8000_0000 | 32'($urandom_range(0, 15));
      else
        cause = 32'($urandom_range(0, 15));
      do_seq(1'($urandom_range(0, 1)), $urandom, cause, int'($urandom_range(0, 3)), 1'b0, 1'b0);
      exu_read(12'h300, m_mstatus);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ysyx_23060203_trap_ctrl.md
# ysyx_23060203_trap_ctrl

Trap sequencer for the machine-mode CSR file. It accepts ECALL/exception and MRET requests from the EXU and sequences the required CSR read/modify/write steps through the CSR file's single read port and two write ports: mepc, mcause, mstatus, and mtvec or mepc. It then issues a PC redirect to the IFU. While idle, it passes the EXU's ordinary CSR-instruction traffic straight through to the CSR file.

## Interface
Parameters:
- none; widths fixed at 32-bit data, 12-bit CSR address.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rstn  in  1  reset; synchronous, active-low.
- trap_valid  in  1  EXU trap request.
- trap_ready  out  1  request accepted when valid&ready.
- trap_kind  in  1  0 = TRAP (exception/ecall), 1 = MRET.
- trap_pc  in  32  PC of the trapping instruction (TRAP only).
- trap_cause  in  32  mcause value (TRAP only).
- exu_csr_raddr  in  12  EXU CSR read address.
- exu_csr_rdata  out  32  EXU CSR read data.
- exu_csr_wen  in  1  EXU CSR write enable.
- exu_csr_waddr  in  12  EXU CSR write address.
- exu_csr_wdata  in  32  EXU CSR write data.
- exu_csr_ready  out  1  EXU CSR access accepted (high only in IDLE).
- csr_raddr  out  12  to CSR file read address.
- csr_rdata  in  32  from CSR file, combinational.
- csr_wen1 / csr_waddr1 / csr_wdata1  out  1/12/32  CSR write port 1.
- csr_wen2 / csr_waddr2 / csr_wdata2  out  1/12/32  CSR write port 2.
- redirect_valid  out  1  new PC available.
- redirect_ready  in  1  IFU takes redirect.
- redirect_pc  out  32  target PC.

## Operation
- FSM states: IDLE, SAVE, VECTOR, RESTORE, LOADEPC, REDIRECT.
- IDLE:
  - trap_ready = exu_csr_ready = 1.
  - csr_raddr = exu_csr_raddr; exu_csr_rdata = csr_rdata.
  - Port 1 mirrors the EXU write; port 2 is idle.
  - An accepted TRAP latches pc/cause and goes to SAVE. An accepted MRET goes to RESTORE.
  - An EXU write in the accept cycle still commits.
- SAVE:
  - Port 1 writes mepc = {pc[31:2], 2'b00}; port 2 writes mcause = cause.
  - csr_raddr = mstatus.
  - Next mstatus is computed: MPIE(7) = MIE(3), MIE = 0, MPP(12:11) = 2'b11. Go to VECTOR.
- VECTOR:
  - Port 1 writes the computed mstatus; csr_raddr = mtvec.
  - Target = {mtvec[31:2], 2'b00}, registered. Go to REDIRECT.
- RESTORE:
  - csr_raddr = mstatus. Port 1 writes mstatus with MIE = MPIE, MPIE = 1, MPP = 2'b11. Go to LOADEPC.
- LOADEPC: csr_raddr = mepc; target = csr_rdata, registered. Go to REDIRECT.
- REDIRECT: redirect_valid = 1 with redirect_pc stable. On redirect_ready, go to IDLE.
- Outside IDLE:
  - trap_ready = exu_csr_ready = 0.
  - EXU writes are not forwarded; the EXU must hold them.
  - exu_csr_rdata = 0.

## Timing
- Request accepted at cycle T. CSR writes occur at T+1 and T+2; redirect_valid rises at T+3 for both kinds.
- Minimum turnaround is 4 cycles; trap_ready is high again at T+4 if the redirect is taken at T+3.
- The write ports never target the same address in the same cycle.
- redirect_valid holds until the handshake completes; redirect_pc does not change while valid.
- trap_valid in a non-IDLE state is ignored (not queued).
- Reset (rstn = 0 at a posedge), including mid-sequence, drives:
  - FSM to IDLE.
  - redirect_valid = 0, redirect_pc = 0.
  - All latched registers to 0.
  - No CSR write issued that cycle; the partial sequence is abandoned.
- Output values during reset:
  - Write enables are 0 whenever rstn = 0, including EXU pass-through.
  - trap_ready and exu_csr_ready are 0 while rstn = 0.

## Configuration
- YSYX_23060203_TRAP_VECTORED_EN defined:
  - mtvec MODE (bits 1:0) is honoured.
  - If MODE = 1 and cause[31] = 1, target = {mtvec[31:2], 2'b00} + (cause[30:0] << 2).
  - Otherwise the target is the base.
- Undefined: MODE bits are ignored; the target is always {mtvec[31:2], 2'b00}.

## Structure
- Package ysyx_23060203_trap_pkg:
  - FSM state enum and trap_kind enum.
  - mstatus bit positions (MIE = 3, MPIE = 7, MPP = 12:11).
  - CSR address constants: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342.
- Sub-module ysyx_23060203_trap_target: combinational mtvec + cause to target PC; contains the vectored logic under the macro.

## Test plan
- Reset with mstatus = 0x1800, mtvec = 0x80000100, then TRAP with pc = 0x80000010, cause = 11:
  - T+1: mepc = 0x80000010, mcause = 11.
  - T+2: mstatus = 0x1800.
  - T+3: redirect 0x80000100.
- MIE set (mstatus = 0x1808), then TRAP → mstatus = 0x1880. Then MRET with mepc = 0x80000014:
  - mstatus = 0x1888.
  - redirect_pc = 0x80000014.
- redirect_ready held low 5 cycles:
  - redirect_valid and redirect_pc stable.
  - trap_ready = 0.
  - New trap_valid ignored.
- EXU write mtvec = 0x80000200 in IDLE commits. An EXU write during SAVE gives exu_csr_ready = 0 and no commit.
- rstn low during VECTOR:
  - Next cycle in IDLE, no mstatus write, redirect_valid = 0.
  - A following TRAP completes normally.
- With YSYX_23060203_TRAP_VECTORED_EN, mtvec = 0x80000101, cause = 0x80000007 → redirect 0x8000011C. Without the macro → redirect 0x80000100.
